set_time_rpt: RTL and testbench
===============================

Name: set_time_rpt

Overview:
Next-generation date/time setter for the clock display.
- Edits a BCD shadow of year/month/day/hour/min/sec, digit by digit, under a cursor.
- Per-button debounce; up/down auto-repeat while held.
- Months and days are always legal: overflow is clamped, including leap years.
- Loads the live time on edit entry and emits a one-cycle commit pulse back to the timekeeper.
- Sits between the button synchronisers/mode FSM and the timekeeping counter.

Parameters:
DEBOUNCE_CYCLES, 2500000, consecutive stable-high cycles before a press is accepted
REPEAT_DELAY, 25000000, further held cycles before the first up/down repeat
REPEAT_PERIOD, 5000000, cycles between subsequent repeats
RESET_YEAR, 16'h2023, BCD year after reset (month/day reset to 01, time to 00:00:00)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
edit_en  in  1  1 = setting mode active
btn_l, btn_r, btn_up, btn_down, btn_mid  in  1 each  raw buttons, active-high, async to clk
cur_year  in  16  live BCD year, loaded on edit entry
cur_month, cur_day, cur_hour, cur_min, cur_sec  in  8 each  live BCD fields
year  out  16  BCD year
month, day, hour, minute, sec  out  8 each  BCD fields
week  out  3  weekday, 0=Sunday..6=Saturday
cursor  out  4  selected digit 0..13
commit  out  1  one-cycle pulse, fields valid

Behaviour:
Reset state:
- Outputs = RESET_YEAR-01-01 00:00:00.
- week = weekday of that date.
- cursor = 13, commit = 0, all counters 0.

Button synchronisation and press qualification:
- Each button passes through a 2-FF synchroniser.
- Per-button counter increments while the synced level is high, clears when low.
- If more than one synced button is high, all counters clear and no action occurs.
- Action fires on the cycle the counter reaches DEBOUNCE_CYCLES.
- up/down only: further actions at DEBOUNCE_CYCLES+REPEAT_DELAY, then every REPEAT_PERIOD while held.
- l/r/mid never repeat.
- While edit_en = 0, all counters are held at 0 and no actions occur.

Edit entry:
- Rising edge of edit_en loads cur_* into the fields and sets cursor = 13.
- Any action in that same cycle is discarded.

Cursor digit map:
- 13..10 = year thousands..units, 9..8 = month, 7..6 = day, 5..4 = hour, 3..2 = minute, 1..0 = sec.
- btn_l: cursor+1, wrapping 13 -> 0.
- btn_r: cursor-1, wrapping 0 -> 13.

Digit edit:
- Per-digit max: year digits 9; month tens 1; day tens 3; hour tens 2; min/sec tens 5; all units digits 9.
- up: digit+1, wraps max -> 0.
- down: digit-1, wraps 0 -> max.
- Only the selected digit changes before normalisation.

Normalisation (same cycle, applied to the next-state value):
1. month 00 -> 01; month > 12 -> 12.
2. day 00 -> 01; day > dim(month, year) -> dim.
3. hour > 23 -> 23.
4. Normalisation also runs after edit-entry load.

Month lengths and leap rule:
- dim: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February 29 if leap, else 28.
- Leap = (y%4==0 and y%100!=0) or y%400==0; year 0000 is leap.

Weekday:
- Registered; valid one cycle after any field change.
- Gregorian Sakamoto algorithm on the binary-converted year/month/day.

Commit:
- btn_mid action pulses commit for exactly one cycle; fields are unchanged.

Latency:
- Field/cursor update on the clock edge of the action cycle, visible the next cycle.

Async reset:
- Reset at any point (including mid-hold or mid-repeat) returns everything to the reset state immediately.
- After release, a still-held button must requalify from count 0.

Test Plan:
(bench parameters DEBOUNCE_CYCLES=3, REPEAT_DELAY=8, REPEAT_PERIOD=4)
- Reset release -> 2023-01-01 00:00:00, week=0, cursor=13, commit=0; glitches shorter than 3 synced cycles on any button -> no change.
- edit_en rises with cur = 2024-03-31 12:34:56 -> fields match after 1 cycle; btn_r once -> cursor 12; btn_l from 13 -> cursor 0.
- From 2024-03-31, cursor 8, btn_down -> 2024-02-29, week=4; repeat with year 2023 -> 2023-02-28, week=2; year 2100 -> day 28; year 2000 -> day 29.
- Month 09, cursor 9, btn_up -> tens 1 -> 19 clamped to 12; hour 19, cursor 5, btn_up -> 29 clamped to 23; sec 59, cursor 0, btn_up -> 50.
- Hold btn_up 20 synced cycles at cursor 0 from sec 00 -> actions at held counts 3, 11, 15, 19 -> sec 04; release -> no further change.
- btn_up+btn_down together -> no change; btn_mid -> exactly one commit pulse; rst_n low mid-repeat -> reset state, no action for 3 cycles after release.

Source files
------------

// File: rtl/set_time_rpt_if.sv
// Button, live-time and edited-field signals between the mode FSM,
// the date/time setter and the timekeeping counter.
interface set_time_rpt_if;
  logic        edit_en;
  logic        btn_l;
  logic        btn_r;
  logic        btn_up;
  logic        btn_down;
  logic        btn_mid;
  logic [15:0] cur_year;
  logic [7:0]  cur_month;
  logic [7:0]  cur_day;
  logic [7:0]  cur_hour;
  logic [7:0]  cur_min;
  logic [7:0]  cur_sec;
  logic [15:0] year;
  logic [7:0]  month;
  logic [7:0]  day;
  logic [7:0]  hour;
  logic [7:0]  minute;
  logic [7:0]  sec;
  logic [2:0]  week;
  logic [3:0]  cursor;
  logic        commit;

  modport master (
    output edit_en, btn_l, btn_r, btn_up, btn_down, btn_mid,
    output cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec,
    input  year, month, day, hour, minute, sec, week, cursor, commit
  );

  modport slave (
    input  edit_en, btn_l, btn_r, btn_up, btn_down, btn_mid,
    input  cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec,
    output year, month, day, hour, minute, sec, week, cursor, commit
  );
endinterface

// File: rtl/set_time_rpt.sv
// BCD date/time setter: debounced cursor/digit editing with auto-repeat,
// calendar clamping, registered weekday and a one-cycle commit pulse.
module set_time_rpt #(
  parameter int unsigned DEBOUNCE_CYCLES = 2500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter logic [15:0] RESET_YEAR      = 16'h2023
) (
  input  logic          clk,
  input  logic          rst_n,
  set_time_rpt_if.slave bus
);

  localparam int unsigned NBTN       = 5;
  localparam int unsigned B_L        = 0;
  localparam int unsigned B_R        = 1;
  localparam int unsigned B_UP       = 2;
  localparam int unsigned B_DN       = 3;
  localparam int unsigned B_MID      = 4;
  localparam int unsigned RPT_FIRE   = DEBOUNCE_CYCLES + REPEAT_DELAY - 1;
  localparam int unsigned RPT_RELOAD = DEBOUNCE_CYCLES + REPEAT_DELAY - REPEAT_PERIOD;
  localparam int unsigned CW         = $clog2(DEBOUNCE_CYCLES + REPEAT_DELAY + 1);
  localparam int unsigned FW         = 56;

  function automatic logic [6:0] bcd_bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [13:0] year_bin(input logic [15:0] y);
    return 14'(y[15:12]) * 14'd1000 + 14'(y[11:8]) * 14'd100 +
           14'(y[7:4]) * 14'd10 + 14'(y[3:0]);
  endfunction

  // Divisibility by 4 from BCD digits: 10*t+u == 2*t+u (mod 4)
  function automatic logic is_leap(input logic [15:0] y);
    logic [4:0] lo;
    logic [4:0] hi;
    lo = 5'({y[7:4], 1'b0}) + 5'(y[3:0]);
    hi = 5'({y[15:12], 1'b0}) + 5'(y[11:8]);
    return (y[7:0] != 8'h00) ? (lo[1:0] == 2'b00) : (hi[1:0] == 2'b00);
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic leap);
    case (m)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return leap ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

  // Sakamoto; +400 years keeps Jan/Feb of year 0000 non-negative
  function automatic logic [2:0] weekday(input logic [15:0] y, input logic [7:0] m,
                                         input logic [7:0] d);
    logic [3:0]  mb;
    logic [15:0] yy;
    logic [15:0] s;
    logic [2:0]  t;
    mb = 4'(bcd_bin(m));
    yy = 16'(year_bin(y)) + 16'd400 - ((mb < 4'd3) ? 16'd1 : 16'd0);
    case (mb)
      4'd2, 4'd6:   t = 3'd3;
      4'd3, 4'd11:  t = 3'd2;
      4'd4:         t = 3'd5;
      4'd7:         t = 3'd5;
      4'd8:         t = 3'd1;
      4'd9, 4'd12:  t = 3'd4;
      4'd10:        t = 3'd6;
      default:      t = 3'd0;
    endcase
    s = yy + yy / 16'd4 - yy / 16'd100 + yy / 16'd400 + 16'(t) + 16'(bcd_bin(d));
    return 3'(s % 16'd7);
  endfunction

  function automatic logic [FW-1:0] normalise(input logic [FW-1:0] f);
    logic [7:0] mo;
    logic [7:0] d;
    logic [7:0] h;
    logic [7:0] dim;
    mo = f[39:32];
    d  = f[31:24];
    h  = f[23:16];
    if (mo == 8'h00)      mo = 8'h01;
    else if (mo > 8'h12)  mo = 8'h12;
    dim = days_in_month(mo, is_leap(f[55:40]));
    if (d == 8'h00)       d = 8'h01;
    else if (d > dim)     d = dim;
    if (h > 8'h23)        h = 8'h23;
    return {f[55:40], mo, d, h, f[15:0]};
  endfunction

  function automatic logic [3:0] digit_max(input logic [3:0] c);
    case (c)
      4'd9:       return 4'd1;
      4'd7:       return 4'd3;
      4'd5:       return 4'd2;
      4'd3, 4'd1: return 4'd5;
      default:    return 4'd9;
    endcase
  endfunction

  logic [NBTN-1:0] r_sync1, r_sync2;
  logic [CW-1:0]   r_cnt [NBTN];
  logic [CW-1:0]   w_cnt_nxt [NBTN];
  logic [NBTN-1:0] w_fire;
  logic            w_multi;
  logic            r_edit_d;
  logic            w_entry;
  logic [FW-1:0]   r_flds, w_flds, w_flds_nxt;
  logic [3:0]      r_cursor, w_cursor_nxt;
  logic [2:0]      r_week;
  logic            r_commit, w_commit_nxt;
  logic [5:0]      w_shift;
  logic [3:0]      w_dig, w_dig_nxt, w_max;
  logic [NBTN-1:0] w_raw;

  assign w_raw   = {bus.btn_mid, bus.btn_down, bus.btn_up, bus.btn_r, bus.btn_l};
  assign w_entry = bus.edit_en & ~r_edit_d;

  // Per-button qualification; up/down reload to produce the repeat cadence
  always_comb begin
    w_multi = ($countones(r_sync2) > 1);
    w_fire  = '0;
    for (int unsigned i = 0; i < NBTN; i++) begin
      w_cnt_nxt[i] = '0;
      if (bus.edit_en && !w_multi && r_sync2[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) w_fire[i] = 1'b1;
        if (i == B_UP || i == B_DN) begin
          if (r_cnt[i] == CW'(RPT_FIRE)) begin
            w_fire[i]    = 1'b1;
            w_cnt_nxt[i] = CW'(RPT_RELOAD);
          end
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
          w_cnt_nxt[i] = r_cnt[i];
        end
      end
    end
  end

  // Field, cursor and commit next state
  always_comb begin
    w_flds       = r_flds;
    w_cursor_nxt = r_cursor;
    w_commit_nxt = 1'b0;
    w_shift      = {r_cursor, 2'b00};
    w_dig        = 4'(r_flds >> w_shift);
    w_max        = digit_max(r_cursor);
    w_dig_nxt    = w_dig;
    if (w_fire[B_UP])
      w_dig_nxt = (w_dig >= w_max) ? 4'd0 : w_dig + 4'd1;
    else if (w_fire[B_DN])
      w_dig_nxt = (w_dig == 4'd0 || w_dig > w_max) ? w_max : w_dig - 4'd1;
    if (w_entry) begin
      w_flds       = {bus.cur_year, bus.cur_month, bus.cur_day,
                      bus.cur_hour, bus.cur_min, bus.cur_sec};
      w_cursor_nxt = 4'd13;
    end else begin
      w_flds = (r_flds & ~(FW'(4'hF) << w_shift)) | (FW'(w_dig_nxt) << w_shift);
      if (w_fire[B_L])
        w_cursor_nxt = (r_cursor >= 4'd13) ? 4'd0 : r_cursor + 4'd1;
      else if (w_fire[B_R])
        w_cursor_nxt = (r_cursor == 4'd0) ? 4'd13 : r_cursor - 4'd1;
      w_commit_nxt = w_fire[B_MID];
    end
    w_flds_nxt = normalise(w_flds);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      for (int unsigned i = 0; i < NBTN; i++) r_cnt[i] <= '0;
      r_edit_d <= 1'b0;
      r_flds   <= {RESET_YEAR, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
      r_cursor <= 4'd13;
      r_week   <= weekday(RESET_YEAR, 8'h01, 8'h01);
      r_commit <= 1'b0;
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      for (int unsigned i = 0; i < NBTN; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_edit_d <= bus.edit_en;
      r_flds   <= w_flds_nxt;
      r_cursor <= w_cursor_nxt;
      r_week   <= weekday(r_flds[55:40], r_flds[39:32], r_flds[31:24]);
      r_commit <= w_commit_nxt;
    end
  end

  assign bus.year   = r_flds[55:40];
  assign bus.month  = r_flds[39:32];
  assign bus.day    = r_flds[31:24];
  assign bus.hour   = r_flds[23:16];
  assign bus.minute = r_flds[15:8];
  assign bus.sec    = r_flds[7:0];
  assign bus.week   = r_week;
  assign bus.cursor = r_cursor;
  assign bus.commit = r_commit;

endmodule

// File: tb/tb_set_time_rpt.sv
// Bench for set_time_rpt: directed calendar/repeat scenarios plus random
// edit sessions against a plain-arithmetic date model.
module tb_set_time_rpt;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  set_time_rpt_if bus ();

  set_time_rpt #(
    .DEBOUNCE_CYCLES(3),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (4),
    .RESET_YEAR     (16'h2023)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (binary values)
  int m_y, m_mo, m_d, m_h, m_mi, m_s, m_cur;

  function automatic logic [15:0] bcd16(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic bit m_leap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int m_dim(input int y, input int mo);
    if (mo == 2) return m_leap(y) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  // Day count since 0001-01-01 (a Monday), shifted by 400 years
  function automatic int m_wday(input int y, input int mo, input int d);
    int cum [12];
    int yy;
    int days;
    cum  = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
    yy   = y + 400 - 1;
    days = 365 * yy + yy / 4 - yy / 100 + yy / 400 + cum[mo - 1] + d;
    if (mo > 2 && m_leap(y)) days++;
    return days % 7;
  endfunction

  function automatic void m_norm();
    if (m_mo == 0) m_mo = 1;
    if (m_mo > 12) m_mo = 12;
    if (m_d == 0) m_d = 1;
    if (m_d > m_dim(m_y, m_mo)) m_d = m_dim(m_y, m_mo);
    if (m_h > 23) m_h = 23;
  endfunction

  function automatic void m_edit(input bit up);
    int dg [14];
    int mx;
    dg[13] = m_y / 1000; dg[12] = (m_y / 100) % 10; dg[11] = (m_y / 10) % 10; dg[10] = m_y % 10;
    dg[9] = m_mo / 10; dg[8] = m_mo % 10; dg[7] = m_d / 10; dg[6] = m_d % 10;
    dg[5] = m_h / 10;  dg[4] = m_h % 10;  dg[3] = m_mi / 10; dg[2] = m_mi % 10;
    dg[1] = m_s / 10;  dg[0] = m_s % 10;
    mx = 9;
    if (m_cur == 9) mx = 1;
    else if (m_cur == 7) mx = 3;
    else if (m_cur == 5) mx = 2;
    else if (m_cur == 3 || m_cur == 1) mx = 5;
    if (up) dg[m_cur] = (dg[m_cur] == mx) ? 0 : dg[m_cur] + 1;
    else    dg[m_cur] = (dg[m_cur] == 0) ? mx : dg[m_cur] - 1;
    m_y  = dg[13] * 1000 + dg[12] * 100 + dg[11] * 10 + dg[10];
    m_mo = dg[9] * 10 + dg[8];
    m_d  = dg[7] * 10 + dg[6];
    m_h  = dg[5] * 10 + dg[4];
    m_mi = dg[3] * 10 + dg[2];
    m_s  = dg[1] * 10 + dg[0];
    m_norm();
  endfunction

  // 0=left 1=right 2=up 3=down 4=mid
  function automatic void m_act(input int b);
    case (b)
      0: m_cur = (m_cur == 13) ? 0 : m_cur + 1;
      1: m_cur = (m_cur == 0) ? 13 : m_cur - 1;
      2: m_edit(1'b1);
      3: m_edit(1'b0);
      default: ;
    endcase
  endfunction

  function automatic logic [59:0] exp_p();
    return {bcd16(m_y), bcd8(m_mo), bcd8(m_d), bcd8(m_h), bcd8(m_mi), bcd8(m_s), 4'(m_cur)};
  endfunction

  function automatic logic [59:0] got_p();
    return {bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.sec, bus.cursor};
  endfunction

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.btn_l    = v;
      1: bus.btn_r    = v;
      2: bus.btn_up   = v;
      3: bus.btn_down = v;
      default: bus.btn_mid = v;
    endcase
  endtask

  task automatic press(input int b, input int n);
    @(negedge clk);
    set_btn(b, 1'b1);
    repeat (n) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  task automatic enter(input int y, input int mo, input int d, input int h,
                       input int mi, input int s);
    @(negedge clk);
    bus.edit_en = 1'b0;
    @(negedge clk);
    bus.cur_year  = bcd16(y);
    bus.cur_month = bcd8(mo);
    bus.cur_day   = bcd8(d);
    bus.cur_hour  = bcd8(h);
    bus.cur_min   = bcd8(mi);
    bus.cur_sec   = bcd8(s);
    bus.edit_en   = 1'b1;
    @(negedge clk);
    m_y = y; m_mo = mo; m_d = d; m_h = h; m_mi = mi; m_s = s; m_cur = 13;
    m_norm();
  endtask

  task automatic goto_cursor(input int target);
    while (m_cur != target) begin
      press(1, 4);
      m_act(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_y = 2023; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0; m_cur = 13;
    n_vec++;
    if (got_p() !== exp_p()) begin
      n_err++; $display("FAIL reset_fields: got %h expected %h", got_p(), exp_p());
    end
    n_vec++;
    if (bus.week !== 3'd0 || bus.commit !== 1'b0) begin
      n_err++; $display("FAIL reset_week_commit: got week=%0d commit=%b expected 0/0", bus.week, bus.commit);
    end
  endtask

  task automatic test_entry_cursor();
    enter(2024, 3, 31, 12, 34, 56);
    n_vec++;
    if (got_p() !== exp_p()) begin
      n_err++; $display("FAIL entry_load: got %h expected %h", got_p(), exp_p());
    end
    for (int b = 0; b < 5; b++) begin
      press(b, 2);
      n_vec++;
      if (got_p() !== exp_p() || bus.commit !== 1'b0) begin
        n_err++; $display("FAIL glitch_btn%0d: got %h expected %h", b, got_p(), exp_p());
      end
    end
    press(1, 4); m_act(1);
    n_vec++;
    if (bus.cursor !== 4'd12) begin
      n_err++; $display("FAIL cursor_right: got %0d expected 12", bus.cursor);
    end
    press(0, 4); m_act(0);
    press(0, 4); m_act(0);
    n_vec++;
    if (bus.cursor !== 4'd0) begin
      n_err++; $display("FAIL cursor_left_wrap: got %0d expected 0", bus.cursor);
    end
  endtask

  task automatic test_leap();
    int years [4];
    years = '{2024, 2023, 2100, 2000};
    for (int k = 0; k < 4; k++) begin
      enter(years[k], 3, 31, 12, 34, 56);
      goto_cursor(8);
      press(3, 4); m_act(3);
      n_vec++;
      if (got_p() !== exp_p()) begin
        n_err++; $display("FAIL leap_%0d: got %h expected %h", years[k], got_p(), exp_p());
      end
      n_vec++;
      if (bus.week !== 3'(m_wday(m_y, m_mo, m_d))) begin
        n_err++; $display("FAIL leap_week_%0d: got %0d expected %0d", years[k], bus.week, m_wday(m_y, m_mo, m_d));
      end
    end
  endtask

  task automatic test_clamp();
    int curs [3];
    curs = '{9, 5, 0};
    enter(2024, 9, 15, 19, 0, 59);
    for (int k = 0; k < 3; k++) begin
      goto_cursor(curs[k]);
      press(2, 4); m_act(2);
      n_vec++;
      if (got_p() !== exp_p()) begin
        n_err++; $display("FAIL clamp_cur%0d: got %h expected %h", curs[k], got_p(), exp_p());
      end
    end
  endtask

  task automatic test_repeat();
    enter(2024, 6, 10, 8, 30, 0);
    goto_cursor(0);
    @(negedge clk);
    bus.btn_up = 1'b1;
    repeat (20) @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (8) @(negedge clk);
    repeat (4) m_act(2);
    n_vec++;
    if (got_p() !== exp_p()) begin
      n_err++; $display("FAIL repeat_hold: got %h expected %h", got_p(), exp_p());
    end
    repeat (20) @(negedge clk);
    n_vec++;
    if (bus.sec !== 8'h04) begin
      n_err++; $display("FAIL repeat_release: got sec %h expected 04", bus.sec);
    end
  endtask

  task automatic test_chord_commit();
    int pulses;
    @(negedge clk);
    bus.btn_up = 1'b1; bus.btn_down = 1'b1;
    repeat (14) @(negedge clk);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    repeat (6) @(negedge clk);
    n_vec++;
    if (got_p() !== exp_p()) begin
      n_err++; $display("FAIL chord_updown: got %h expected %h", got_p(), exp_p());
    end
    pulses = 0;
    bus.btn_mid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 5) bus.btn_mid = 1'b0;
      if (bus.commit === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 1 || got_p() !== exp_p()) begin
      n_err++; $display("FAIL commit_pulse: got %0d pulses fields %h expected 1 pulse fields %h", pulses, got_p(), exp_p());
    end
  endtask

  task automatic test_reset_mid_repeat();
    enter(2023, 1, 1, 0, 0, 0);
    @(negedge clk);
    bus.btn_up = 1'b1;
    repeat (16) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_y = 2023; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0; m_cur = 13;
    n_vec++;
    if (got_p() !== exp_p() || bus.commit !== 1'b0) begin
      n_err++; $display("FAIL reset_async: got %h expected %h", got_p(), exp_p());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (got_p() !== exp_p()) begin
        n_err++; $display("FAIL reset_requal_c%0d: got %h expected %h", k, got_p(), exp_p());
      end
    end
    repeat (5) @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (8) @(negedge clk);
    m_act(2);
    n_vec++;
    if (got_p() !== exp_p()) begin
      n_err++; $display("FAIL reset_requal_fire: got %h expected %h", got_p(), exp_p());
    end
  endtask

  task automatic test_random();
    int b;
    for (int r = 0; r < 5; r++) begin
      enter(int'($urandom_range(1, 9999)), int'($urandom_range(0, 19)), int'($urandom_range(0, 39)),
            int'($urandom_range(0, 29)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
      @(negedge clk);
      n_vec++;
      if (got_p() !== exp_p() || bus.week !== 3'(m_wday(m_y, m_mo, m_d))) begin
        n_err++; $display("FAIL rand_entry%0d: got %h w%0d expected %h w%0d", r, got_p(), bus.week, exp_p(), m_wday(m_y, m_mo, m_d));
      end
      for (int k = 0; k < 10; k++) begin
        b = int'($urandom_range(0, 3));
        press(b, 4);
        m_act(b);
        n_vec++;
        if (got_p() !== exp_p() || bus.week !== 3'(m_wday(m_y, m_mo, m_d))) begin
          n_err++; $display("FAIL rand_r%0d_a%0d_btn%0d: got %h w%0d expected %h w%0d", r, k, b, got_p(), bus.week, exp_p(), m_wday(m_y, m_mo, m_d));
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.edit_en = 1'b0;
    bus.btn_l = 1'b0; bus.btn_r = 1'b0; bus.btn_up = 1'b0;
    bus.btn_down = 1'b0; bus.btn_mid = 1'b0;
    bus.cur_year = 16'h0000; bus.cur_month = 8'h00; bus.cur_day = 8'h00;
    bus.cur_hour = 8'h00; bus.cur_min = 8'h00; bus.cur_sec = 8'h00;
    test_reset();
    test_entry_cursor();
    test_leap();
    test_clamp();
    test_repeat();
    test_chord_commit();
    test_reset_mid_repeat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
